// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in / parallel-out word assembler with a
// valid/ready handshake on the parallel side and a sticky overrun flag.
// Bits arrive MSB-first on 'a' when 'en' is high. After WIDTH bits the
// word is registered on 's' and held until 'ready' accepts it.
// Optional feature: define SIPO_PARITY_EN to register the XOR of 's' on
// 'parity'. Without it, 'parity' is tied low and no parity logic exists.
module sipo_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             en,
  input  logic             ready,
  output logic [WIDTH-1:0] s,
  output logic             valid,
  output logic             overrun,
  output logic             parity
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // Only the first WIDTH-1 bits of a word need storage: the final bit
  // is taken straight from 'a' on the completing edge.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             ovr_q, ovr_d;
  logic             load;
  logic [WIDTH-1:0] shifted;

  assign shifted = {shreg_q, a};

  // Next-state, datapath and flag updates for the three-state controller
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    s_d     = s_q;
    ovr_d   = ovr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE, SHIFT: begin
        if (en) begin
          shreg_d = shifted[WIDTH-2:0];
          if (count_q == LAST) begin
            s_d     = shifted;
            load    = 1'b1;
            count_d = '0;
            state_d = HOLD;
          end else begin
            count_d = count_q + CW'(1);
            state_d = SHIFT;
          end
        end
      end
      HOLD: begin
        if (ready) begin
          // Transfer; a bit arriving on the same edge starts the next word.
          if (en) begin
            shreg_d = shifted[WIDTH-2:0];
            count_d = CW'(1);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (en) begin
          // Nowhere to put the bit while a word is pending: drop it.
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, counter, shift register, output word and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      shreg_q <= '0;
      s_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      s_q     <= s_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_q;

  // Parity is captured on the same edge as the word it describes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    par_q <= 1'b0;
    else if (load) par_q <= ^s_d;
  end

  assign parity = par_q;
`else
  assign parity = 1'b0;
`endif

  assign s       = s_q;
  assign valid   = (state_q == HOLD);
  assign overrun = ovr_q;

`ifndef SYNTHESIS
  // A pending word must not change until it has been accepted
  hold_stable_a: assert property (@(posedge clk) disable iff (!reset)
    (state_q == HOLD && !ready) |=> ($stable(s_q) && state_q == HOLD));
  // The counter is idle whenever a word is pending
  hold_count_a: assert property (@(posedge clk) disable iff (!reset)
    (state_q == HOLD) |-> (count_q == '0));
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer (WIDTH=8). Expected words are queued as
// their bits are driven and popped when the DUT presents them.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, en, ready;
  logic [7:0] s;
  logic       valid, overrun, parity;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_w;

  sipo_deserializer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .a(a), .en(en), .ready(ready),
    .s(s), .valid(valid), .overrun(overrun), .parity(parity)
  );

  always #5 clk = ~clk;

  function automatic logic exp_par(input logic [7:0] w);
`ifdef SIPO_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    en = 1'b1; a = b;
    tick();
    en = 1'b0; a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; a = 1'b0; en = 1'b0; ready = 1'b0;
    tick(); tick();
    checks++;
    if ({s, valid, overrun, parity} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state got s=%h v=%b o=%b p=%b want all 0", s, valid, overrun, parity);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_assembly();
    logic [7:0] w;
    w = 8'hB2;
    ready = 1'b0;
    sb_q.push_back(w);
    for (int i = 7; i >= 1; i--) drive_bit(w[i]);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL assembly_early_valid got %b want 0", valid);
    end
    drive_bit(w[0]);
    exp_w = sb_q.pop_front();
    checks++;
    if (valid !== 1'b1 || s !== exp_w) begin
      errors++;
      $display("FAIL assembly_word got v=%b s=%h want v=1 s=%h", valid, s, exp_w);
    end
    checks++;
    if (parity !== exp_par(exp_w)) begin
      errors++;
      $display("FAIL assembly_parity got %b want %b", parity, exp_par(exp_w));
    end
    // Idle cycles with ready low: word must stay put
    tick(); tick();
    checks++;
    if (valid !== 1'b1 || s !== 8'hB2) begin
      errors++;
      $display("FAIL hold_stable got v=%b s=%h want v=1 s=b2", valid, s);
    end
  endtask

  task automatic test_handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || s !== 8'hB2 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL handshake got v=%b s=%h o=%b want v=0 s=b2 o=0", valid, s, overrun);
    end
    // ready is meaningless outside HOLD
    ready = 1'b1;
    tick(); tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_idle got v=%b want 0", valid);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] w;
    w = 8'h5C;
    sb_q.push_back(w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    exp_w = sb_q.pop_front();
    checks++;
    if (valid !== 1'b1 || s !== exp_w || parity !== exp_par(exp_w)) begin
      errors++;
      $display("FAIL overrun_word got v=%b s=%h p=%b want v=1 s=%h p=%b",
               valid, s, parity, exp_w, exp_par(exp_w));
    end
    drive_bit(1'b1);
    checks++;
    if (overrun !== 1'b1 || valid !== 1'b1 || s !== 8'h5C) begin
      errors++;
      $display("FAIL overrun_drop got o=%b v=%b s=%h want o=1 v=1 s=5c", overrun, valid, s);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got v=%b o=%b want v=0 o=1", valid, overrun);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] w;
    logic [7:0] tail;
    w = 8'h3A;
    sb_q.push_back(w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    exp_w = sb_q.pop_front();
    checks++;
    if (valid !== 1'b1 || s !== exp_w) begin
      errors++;
      $display("FAIL simul_first got v=%b s=%h want v=1 s=%h", valid, s, exp_w);
    end
    sb_q.push_back(8'h81);
    ready = 1'b1; en = 1'b1; a = 1'b1;
    tick();
    ready = 1'b0; en = 1'b0; a = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_transfer got v=%b want 0", valid);
    end
    tail = 8'h01;
    for (int i = 6; i >= 0; i--) drive_bit(tail[i]);
    exp_w = sb_q.pop_front();
    checks++;
    if (valid !== 1'b1 || s !== exp_w || parity !== exp_par(exp_w)) begin
      errors++;
      $display("FAIL simul_word got v=%b s=%h p=%b want v=1 s=%h p=%b",
               valid, s, parity, exp_w, exp_par(exp_w));
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL simul_overrun_kept got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_midword();
    // Leave the 8'h81 word pending, then transfer it and start a new one
    ready = 1'b1;
    tick();
    ready = 1'b0;
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    // Assert reset between clock edges: outputs must clear at once
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({s, valid, overrun, parity} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async got s=%h v=%b o=%b p=%b want all 0", s, valid, overrun, parity);
    end
    tick();
    reset = 1'b1;
    tick();
    begin
      logic [7:0] w;
      w = 8'h0F;
      sb_q.push_back(w);
      for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    end
    exp_w = sb_q.pop_front();
    checks++;
    if (valid !== 1'b1 || s !== exp_w || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh_word got v=%b s=%h o=%b want v=1 s=%h o=0", valid, s, overrun, exp_w);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      w = 8'($urandom_range(0, 255));
      if (n == 0) w = 8'hFF;
      if (n == 1) w = 8'h00;
      sb_q.push_back(w);
      for (int i = 7; i >= 0; i--) drive_bit(w[i]);
      // drive_bit leaves en low; immediately re-raise for the next word
      exp_w = sb_q.pop_front();
      checks++;
      if (valid !== 1'b1 || s !== exp_w || parity !== exp_par(exp_w)) begin
        errors++;
        $display("FAIL b2b_word%0d got v=%b s=%h p=%b want v=1 s=%h p=%b",
                 n, valid, s, parity, exp_w, exp_par(exp_w));
      end
    end
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got v=%b o=%b want v=0 o=0", valid, overrun);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_assembly();
    test_handshake();
    test_overrun();
    test_simultaneous();
    test_reset_midword();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
